mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/adder.sv | 18 +
 rtl/mul_div_unit.sv | 200 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU package: operation encodings for the integer ALU and the
// iterative multiply/divide unit, plus small op-classification helpers.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    function automatic logic op_is_div(input mdu_op_t op);
        return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    endfunction

    function automatic logic op_a_signed(input mdu_op_t op);
        return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic op_b_signed(input mdu_op_t op);
        return op inside {MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

endpackage

// File: rtl/adder.sv
// Generic ripple adder/subtractor; carry_out doubles as the "no borrow" flag
// when subtracting.
module adder #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, (is_sub ? ~b : b)} + {{WIDTH{1'b0}}, is_sub};
    assign {carry_out, sum} = full;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide unit: one radix-2 step per cycle,
// magnitudes internally, sign fixup when the last step retires.
module mul_div_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output mdu_state_t       dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and producers hold data until transfer.

    mdu_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    mdu_op_t          op_q, op_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             fire;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] special_res;
    logic             is_div_q;

    logic [WIDTH:0]   add_a, add_b, add_sum;
    logic             add_sub, add_cout;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, fixed_res;

    assign in_ready  = (state_q == MDU_IDLE);
    assign out_valid = (state_q == MDU_DONE);
    assign result    = result_q;
    assign dbg_state = state_q;
    assign fire      = in_valid && in_ready;
    assign is_div_q  = op_is_div(op_q);

    // Request decode: signs, magnitudes and the two early-exit divide cases.
    always_comb begin
        a_neg    = op_a_signed(op) && a[WIDTH-1];
        b_neg    = op_b_signed(op) && b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = op_is_div(op) && (b == '0);
        div_ovf  = (op == MDU_DIV || op == MDU_REM) && (a == MOST_NEG) && (b == '1);
        if (div_zero) begin
            special_res = (op == MDU_DIV || op == MDU_DIVU) ? '1 : a;
        end else begin
            special_res = (op == MDU_DIV) ? a : '0;
        end
    end

    always_comb begin
        if (is_div_q) begin
            add_a   = {hi_q, lo_q[WIDTH-1]};
            add_b   = {1'b0, dvs_q};
            add_sub = 1'b1;
        end else begin
            add_a   = {1'b0, hi_q};
            add_b   = lo_q[0] ? {1'b0, dvs_q} : '0;
            add_sub = 1'b0;
        end
    end

    adder #(.WIDTH(WIDTH + 1)) u_adder (
        .a         (add_a),
        .b         (add_b),
        .is_sub    (add_sub),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    // Divide: carry out means the trial subtract did not borrow.
    always_comb begin
        if (is_div_q) begin
            if (add_cout) begin
                hi_nxt = add_sum[WIDTH-1:0];
                lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt = add_sum[WIDTH:1];
            lo_nxt = {add_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod     = {hi_nxt, lo_nxt};
        prod_fix = q_neg_q ? -prod : prod;
        quot_fix = q_neg_q ? -lo_nxt : lo_nxt;
        rem_fix  = r_neg_q ? -hi_nxt : hi_nxt;
        case (op_q)
            MDU_MUL:                         fixed_res = prod_fix[WIDTH-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fixed_res = prod_fix[2*WIDTH-1:WIDTH];
            MDU_DIV, MDU_DIVU:               fixed_res = quot_fix;
            default:                         fixed_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dvs_d    = dvs_q;
        op_d     = op_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        case (state_q)
            MDU_IDLE: begin
                if (fire) begin
                    op_d = op;
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = MDU_DONE;
                    end else begin
                        state_d = MDU_CALC;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = a_mag;
                        dvs_d   = b_mag;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                    end
                end
            end
            MDU_CALC: begin
                hi_d = hi_nxt;
                lo_d = lo_nxt;
                if (cnt_q == LAST_STEP) begin
                    state_d  = MDU_DONE;
                    result_d = fixed_res;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MDU_DONE: begin
                if (out_ready) begin
                    state_d = MDU_IDLE;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
        // Flush wins over everything and leaves the visible result untouched.
        if (flush) begin
            state_d  = MDU_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dvs_q    <= '0;
            op_q     <= MDU_MUL;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dvs_q    <= dvs_d;
            op_q     <= op_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases, randomized ops
// against an arithmetic reference model, stall, flush and mid-op reset.
module tb_mul_div_unit;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int CALC_LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    mdu_op_t      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    mdu_state_t   dbg_state;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] last_res = '0;
    logic [W-1:0] exp_q[$];

    mul_div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: RV32M semantics from plain 64-bit and signed arithmetic.
    function automatic logic [W-1:0] model(input mdu_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint       sx, sy, ux, uy;
        logic [63:0]  p;
        logic         ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'({32'b0, x});
        uy  = longint'({32'b0, y});
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            MDU_MUL:    begin p = 64'(ux * uy); return p[31:0];  end
            MDU_MULH:   begin p = 64'(sx * sy); return p[63:32]; end
            MDU_MULHSU: begin p = 64'(sx * uy); return p[63:32]; end
            MDU_MULHU:  begin p = 64'(ux * uy); return p[63:32]; end
            MDU_DIV:    return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
            MDU_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            MDU_REM:    return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
            default:    return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int model_lat(input mdu_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
        if (o inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU} && y == 0) return 1;
        if (o inside {MDU_DIV, MDU_REM} && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return CALC_LAT;
    endfunction

    // Leaves the caller #1 after the accepting edge.
    task automatic issue(input mdu_op_t o, input logic [W-1:0] x, input logic [W-1:0] y, input logic rdy);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", in_ready, w);
        end
        op        = o;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Keeps requesting garbage while busy; the unit must ignore it.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            in_valid = 1'b1;
            op       = mdu_op_t'($urandom_range(0, 7));
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_op(input mdu_op_t o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_res, input int exp_lat, input int hold, input string name);
        int lat;
        issue(o, x, y, hold == 0);
        wait_result(lat);
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (result !== exp_res) begin
            n_fail++;
            $display("FAIL %s_result: op=%s a=%h b=%h got %h, required %h", name, o.name(), x, y, result, exp_res);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_res) begin
                n_fail++;
                $display("FAIL %s_stall[%0d]: out_valid=%b in_ready=%b result=%h, required 1 0 %h",
                         name, i, out_valid, in_ready, result, exp_res);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b, required 0 1", name, out_valid, in_ready);
        end
        last_res = exp_res;
    endtask

    task automatic watch_quiet(input int cycles, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL %s_quiet: out_valid seen %0d cycles, required 0", name, seen);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = MDU_MUL;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || dbg_state !== MDU_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h state=%0d, required 1 0 0 0",
                     in_ready, out_valid, result, dbg_state);
        end
    endtask

    task automatic test_directed();
        run_op(MDU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, CALC_LAT, 0, "mul_7_m3");
        run_op(MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, CALC_LAT, 0, "mulhu_max");
        run_op(MDU_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, CALC_LAT, 0, "mulhsu_m1_2");
        run_op(MDU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, CALC_LAT, 0, "div_m7_2");
        run_op(MDU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, CALC_LAT, 0, "rem_m7_2");
        run_op(MDU_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1,        0, "divu_by0");
        run_op(MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1,        0, "rem_ovf");
        run_op(MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,        0, "div_ovf");
        run_op(MDU_REMU,   32'd1234,       32'd0,         32'd1234,      1,        0, "remu_by0");
        run_op(MDU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, CALC_LAT, 0, "mulh_minsq");
    endtask

    task automatic test_stall();
        run_op(MDU_MUL, 32'd1000, 32'd1000, 32'd1_000_000, CALC_LAT, 5, "stall_mul");
        run_op(MDU_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 5, "stall_div0");
    endtask

    task automatic test_random();
        mdu_op_t      o;
        logic [W-1:0] x, y;
        int           sel;
        for (int n = 0; n < 40; n++) begin
            o   = mdu_op_t'($urandom_range(0, 7));
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) y = '0;
            if (sel == 1) begin x = 32'h8000_0000; y = '1; end
            if (sel == 2) x = 32'h8000_0000;
            if (sel == 3) y = 32'($urandom_range(1, 20));
            exp_q.push_back(model(o, x, y));
            run_op(o, x, y, exp_q.pop_front(), model_lat(o, x, y), $urandom_range(0, 2), "random");
        end
    endtask

    task automatic test_flush();
        issue(MDU_MUL, 32'd3, 32'd5, 1'b1);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if (dbg_state !== MDU_IDLE || in_ready !== 1'b1 || out_valid !== 1'b0 || result !== last_res) begin
            n_fail++;
            $display("FAIL flush_calc: state=%0d in_ready=%b out_valid=%b result=%h, required 0 1 0 %h",
                     dbg_state, in_ready, out_valid, result, last_res);
        end
        watch_quiet(40, "flush_calc");

        // Flush beats a simultaneous handshake.
        @(negedge clk);
        op       = MDU_MUL;
        a        = 32'd11;
        b        = 32'd13;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (dbg_state !== MDU_IDLE || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_vs_accept: state=%0d in_ready=%b, required 0 1", dbg_state, in_ready);
        end
        watch_quiet(40, "flush_vs_accept");

        // Flush while a result waits for a stalled consumer.
        issue(MDU_DIVU, 32'd9, 32'd0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL flush_done: out_valid=%b in_ready=%b result=%h, required 0 1 ffffffff",
                     out_valid, in_ready, result);
        end
        out_ready = 1'b1;
        run_op(MDU_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h1, CALC_LAT, 0, "after_flush");
    endtask

    task automatic test_reset_mid_calc();
        issue(MDU_MUL, 32'd123, 32'd456, 1'b1);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || dbg_state !== MDU_IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_calc: out_valid=%b in_ready=%b result=%h state=%0d, required 0 1 0 0",
                     out_valid, in_ready, result, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || result !== '0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b result=%h, required 1 0", in_ready, result);
        end
        watch_quiet(40, "reset_mid_calc");
        run_op(MDU_DIVU, 32'd100, 32'd7, 32'd14, CALC_LAT, 0, "after_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_flush();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
